cv32e40p_retire_trace_buffer: RTL and testbench
===============================================

Name: cv32e40p_retire_trace_buffer

Overview:
- Captures one record per retired instruction from the core's writeback stage (PC, instruction word, destination register write) into a DEPTH-entry FIFO.
- Drains the records to a trace sink over a valid/ready stream.
- Sits directly downstream of the core's ID/WB tracing taps and replaces the simulation-only tracer for synthesizable trace export.
- When full, it drops records, counts the drops and marks the gap. It never stalls the core.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, >= 2.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- enable_i  input  1  tracing enable; when low, retire events are ignored and not counted as drops
- clear_i  input  1  synchronous flush of FIFO, counters and flags
- retire_valid_i  input  1  one-cycle pulse per retired instruction
- retire_pc_i  input  32  PC of the retired instruction
- retire_instr_i  input  32  instruction word (expanded form if compressed)
- retire_compressed_i  input  1  instruction was RVC
- retire_rd_we_i  input  1  instruction wrote a register
- retire_rd_addr_i  input  6  destination register; bit 5 selects the FP register file
- retire_rd_wdata_i  input  32  written data
- trace_valid_o  output  1  head record valid
- trace_ready_i  input  1  sink accepts the head record
- trace_pc_o  output  32  head PC
- trace_instr_o  output  32  head instruction
- trace_flags_o  output  3  {gap, compressed, rd_we}
- trace_rd_addr_o  output  6  head rd address
- trace_rd_wdata_o  output  32  head rd data
- fill_level_o  output  $clog2(DEPTH+1)  number of occupied entries
- overflow_o  output  1  sticky: at least one record has been dropped
- drop_count_o  output  DROP_CNT_W  dropped records, saturating

Behaviour:
- **Reset values.** All outputs are 0, the FIFO is empty, pending_gap is 0, and the pointers are 0. Reset applies mid-operation with no residue.
- **Storage.** Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits plus a count register. Pointers wrap modulo DEPTH.
- **Definitions.**
  - push_req = retire_valid_i & enable_i & ~clear_i
  - pop = trace_valid_o & trace_ready_i
  - accept = push_req & (count < DEPTH | pop); a full FIFO accepts a push in the same cycle as a pop.
  - drop = push_req & ~accept
- **Latency.** A record accepted at edge N appears on the trace_* outputs after that edge (cycle N+1) if the FIFO was empty. Outputs are driven from the head entry; there is no combinational path from retire_* to trace_*.
- **Count update.** count increments on accept & ~pop, decrements on pop & ~accept, and is otherwise unchanged. fill_level_o = count.
- **Output stability.** trace_valid_o = (count != 0). While trace_valid_o & ~trace_ready_i, all trace_* outputs hold stable.
- **Gap marking.**
  - On drop: pending_gap <= 1, overflow_o <= 1, and drop_count_o increments, saturating at all-ones.
  - The next accepted record stores gap = pending_gap, and pending_gap clears in the same cycle.
  - If a drop and an accept cannot coincide (same single push_req), no further gap rules apply.
- **Flags.** The stored flags are {gap, retire_compressed_i, retire_rd_we_i}. When rd_we = 0, rd_addr and rd_wdata are stored as 0.
- **clear_i.** On the next edge: count = 0, pointers = 0, overflow_o = 0, drop_count_o = 0, pending_gap = 0.
  - A simultaneous retire event is discarded and not counted.
  - A simultaneous pop is irrelevant because the FIFO is cleared.
  - clear_i dominates all other events.
- **enable_i low.** Blocks new pushes only. Draining continues, and pending_gap and the counters are untouched.
- **Synthesis.** No latches, and no X propagation from unused entries; the memory may be uninitialised, but trace_* are masked to 0 when trace_valid_o = 0.

Test Plan:
1. **Basic pass-through.** DEPTH=8, trace_ready_i=1, one retire of PC 0x0000_1000, instr 0x0050_0093 (addi x1,x0,5), rd_we=1, rd=1, wdata=5. Required: trace_valid_o=1 exactly one cycle later with identical fields, flags=3'b001, fill_level_o back to 0.
2. **Fill then overflow.** trace_ready_i=0, 10 consecutive retires with PCs 0x100, 0x104, …. Required:
   - fill_level_o=8, drop_count_o=2, overflow_o=1.
   - Then ready=1 with one more retire (PC 0x128): the eight stored PCs 0x100–0x11C drain in order, followed by the 0x128 record with gap=1.
3. **Push on full with simultaneous pop.** FIFO full, trace_ready_i=1 and a retire in the same cycle. Required: drop_count_o unchanged, fill_level_o stays 8, new record appended.
4. **Backpressure stability.** Head record valid, trace_ready_i held 0 for 5 cycles while 3 retires arrive. Required: trace_* unchanged for all 5 cycles, fill_level_o increases by 3.
5. **Clear and enable.**
   - clear_i asserted together with a retire on a partly filled FIFO with overflow set. Required: next cycle fill_level_o=0, overflow_o=0, drop_count_o=0, and the discarded record is never seen.
   - enable_i=0 with 4 retires. Required: no change to any counter.
6. **Saturation and async reset.**
   - DROP_CNT_W=4, 20 drops. Required: drop_count_o=4'hF.
   - rst_ni pulsed low mid-drain, asynchronously. Required: all outputs are 0 before the next clock edge.

Source files
------------

// File: rtl/cv32e40p_retire_trace_buffer.sv
// Retire trace buffer: captures one record per retired instruction into a circular FIFO
// and drains it to a trace sink. When full it drops records and never stalls the core.
module cv32e40p_retire_trace_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         retire_valid_i,
  input  logic [31:0]                  retire_pc_i,
  input  logic [31:0]                  retire_instr_i,
  input  logic                         retire_compressed_i,
  input  logic                         retire_rd_we_i,
  input  logic [5:0]                   retire_rd_addr_i,
  input  logic [31:0]                  retire_rd_wdata_i,
  output logic                         trace_valid_o,
  input  logic                         trace_ready_i,
  output logic [31:0]                  trace_pc_o,
  output logic [31:0]                  trace_instr_o,
  output logic [2:0]                   trace_flags_o,
  output logic [5:0]                   trace_rd_addr_o,
  output logic [31:0]                  trace_rd_wdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level_o,
  output logic                         overflow_o,
  output logic [DROP_CNT_W-1:0]        drop_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [2:0]  flags_mem [DEPTH];
  logic [5:0]  rd_mem    [DEPTH];
  logic [31:0] wdata_mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  pending_gap;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic push_req, pop, accept, drop;

  // Sink handshake: a record transfers on a cycle where trace_valid_o & trace_ready_i;
  // while valid is high and ready is low the head record is held unchanged.
  assign trace_valid_o = (count != '0);
  assign pop           = trace_valid_o & trace_ready_i;
  assign push_req      = retire_valid_i & enable_i & ~clear_i;
  assign accept        = push_req & ((count < DEPTH_C) | pop);
  assign drop          = push_req & ~accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending_gap <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt    <= '0;
    end else if (clear_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending_gap <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept & ~pop)      count <= count + 1'b1;
      else if (pop & ~accept) count <= count - 1'b1;
      if (drop) begin
        pending_gap <= 1'b1;
        overflow_q  <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end else if (accept) begin
        pending_gap <= 1'b0;
      end
    end
  end

  // Storage is not reset; the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pc_mem[wr_ptr]    <= retire_pc_i;
      instr_mem[wr_ptr] <= retire_instr_i;
      flags_mem[wr_ptr] <= {pending_gap, retire_compressed_i, retire_rd_we_i};
      rd_mem[wr_ptr]    <= retire_rd_we_i ? retire_rd_addr_i : 6'd0;
      wdata_mem[wr_ptr] <= retire_rd_we_i ? retire_rd_wdata_i : 32'd0;
    end
  end

  assign trace_pc_o       = trace_valid_o ? pc_mem[rd_ptr]    : '0;
  assign trace_instr_o    = trace_valid_o ? instr_mem[rd_ptr] : '0;
  assign trace_flags_o    = trace_valid_o ? flags_mem[rd_ptr] : '0;
  assign trace_rd_addr_o  = trace_valid_o ? rd_mem[rd_ptr]    : '0;
  assign trace_rd_wdata_o = trace_valid_o ? wdata_mem[rd_ptr] : '0;

  assign fill_level_o = count;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt;

endmodule

// File: tb/tb_cv32e40p_retire_trace_buffer.sv
// Bench for the retire trace buffer: a 16-bit and a 4-bit drop-counter instance share stimulus
// and are checked against a queue-based model of the record stream.
module tb_cv32e40p_retire_trace_buffer;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  flags;
    logic [5:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rec_t;

  logic        clk, rst_n, enable, clear, retire_valid, retire_compressed, retire_rd_we, trace_ready;
  logic [31:0] retire_pc, retire_instr, retire_rd_wdata;
  logic [5:0]  retire_rd_addr;

  logic        t_valid, t_ovf, s_valid, s_ovf;
  logic [31:0] t_pc, t_instr, t_wdata, s_pc, s_instr, s_wdata;
  logic [2:0]  t_flags, s_flags;
  logic [5:0]  t_rd, s_rd;
  logic [3:0]  t_fill, s_fill;
  logic [15:0] t_drop;
  logic [3:0]  s_drop;
  rec_t        t_head;
  assign t_head = {t_pc, t_instr, t_flags, t_rd, t_wdata};

  rec_t exp_q[$];
  int   drop_total;
  bit   m_gap, m_ovf;
  int   n_tests, n_fail;

  cv32e40p_retire_trace_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .retire_valid_i(retire_valid), .retire_pc_i(retire_pc), .retire_instr_i(retire_instr),
    .retire_compressed_i(retire_compressed), .retire_rd_we_i(retire_rd_we),
    .retire_rd_addr_i(retire_rd_addr), .retire_rd_wdata_i(retire_rd_wdata),
    .trace_valid_o(t_valid), .trace_ready_i(trace_ready), .trace_pc_o(t_pc),
    .trace_instr_o(t_instr), .trace_flags_o(t_flags), .trace_rd_addr_o(t_rd),
    .trace_rd_wdata_o(t_wdata), .fill_level_o(t_fill), .overflow_o(t_ovf), .drop_count_o(t_drop));

  cv32e40p_retire_trace_buffer #(.DEPTH(DEPTH), .DROP_CNT_W(4)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .retire_valid_i(retire_valid), .retire_pc_i(retire_pc), .retire_instr_i(retire_instr),
    .retire_compressed_i(retire_compressed), .retire_rd_we_i(retire_rd_we),
    .retire_rd_addr_i(retire_rd_addr), .retire_rd_wdata_i(retire_rd_wdata),
    .trace_valid_o(s_valid), .trace_ready_i(trace_ready), .trace_pc_o(s_pc),
    .trace_instr_o(s_instr), .trace_flags_o(s_flags), .trace_rd_addr_o(s_rd),
    .trace_rd_wdata_o(s_wdata), .fill_level_o(s_fill), .overflow_o(s_ovf), .drop_count_o(s_drop));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic rec_t exp_head();
    if (exp_q.size() == 0) return '0;
    return exp_q[0];
  endfunction

  function automatic int exp_drop(input int max);
    return (drop_total > max) ? max : drop_total;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    drop_total = 0;
    m_gap = 0;
    m_ovf = 0;
  endtask

  task automatic model_step();
    bit   do_pop, req;
    rec_t r;
    do_pop = (exp_q.size() != 0) && trace_ready;
    req    = retire_valid && enable && !clear;
    if (clear) begin
      model_reset();
    end else begin
      if (req && (exp_q.size() < DEPTH || do_pop)) begin
        r.pc       = retire_pc;
        r.instr    = retire_instr;
        r.flags    = {m_gap, retire_compressed, retire_rd_we};
        r.rd_addr  = retire_rd_we ? retire_rd_addr : 6'd0;
        r.rd_wdata = retire_rd_we ? retire_rd_wdata : 32'd0;
        if (do_pop) void'(exp_q.pop_front());
        exp_q.push_back(r);
        m_gap = 0;
      end else begin
        if (do_pop) void'(exp_q.pop_front());
        if (req) begin
          drop_total++;
          m_ovf = 1;
          m_gap = 1;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    retire_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic drive_retire(input logic [31:0] pc);
    retire_valid      = 1'b1;
    retire_pc         = pc;
    retire_instr      = $urandom();
    retire_compressed = 1'($urandom_range(0, 1));
    retire_rd_we      = 1'($urandom_range(0, 1));
    retire_rd_addr    = 6'($urandom_range(0, 63));
    retire_rd_wdata   = $urandom();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; retire_valid = 1'b0; trace_ready = 1'b0;
    retire_pc = '0; retire_instr = '0; retire_compressed = 1'b0; retire_rd_we = 1'b0;
    retire_rd_addr = '0; retire_rd_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", t_valid); end
    n_tests++; if (t_head !== '0) begin n_fail++; $display("FAIL reset_head got %h exp 0", t_head); end
    n_tests++; if (t_fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", t_fill); end
    n_tests++; if (t_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", t_ovf); end
    n_tests++; if (t_drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", t_drop); end
    n_tests++; if (s_drop !== 4'd0) begin n_fail++; $display("FAIL reset_sdrop got %0d exp 0", s_drop); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b exp 0", t_valid); end
  endtask

  task automatic test_pass_through();
    trace_ready = 1'b1;
    retire_valid = 1'b1; retire_pc = 32'h0000_1000; retire_instr = 32'h0050_0093;
    retire_compressed = 1'b0; retire_rd_we = 1'b1; retire_rd_addr = 6'd1; retire_rd_wdata = 32'd5;
    n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL pt_comb_path got %b exp 0", t_valid); end
    tick();
    n_tests++; if (t_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid got %b exp 1", t_valid); end
    n_tests++; if (t_pc !== 32'h1000) begin n_fail++; $display("FAIL pt_pc got %h exp 1000", t_pc); end
    n_tests++; if (t_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL pt_instr got %h exp 00500093", t_instr); end
    n_tests++; if (t_flags !== 3'b001) begin n_fail++; $display("FAIL pt_flags got %b exp 001", t_flags); end
    n_tests++; if (t_rd !== 6'd1) begin n_fail++; $display("FAIL pt_rd got %0d exp 1", t_rd); end
    n_tests++; if (t_wdata !== 32'd5) begin n_fail++; $display("FAIL pt_wdata got %h exp 5", t_wdata); end
    tick();
    n_tests++; if (t_fill !== 4'd0) begin n_fail++; $display("FAIL pt_fill got %0d exp 0", t_fill); end
    n_tests++; if (t_head !== '0) begin n_fail++; $display("FAIL pt_masked got %h exp 0", t_head); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] exp_pc;
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_retire(32'h100 + 32'(4 * i));
      tick();
    end
    n_tests++; if (t_fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill got %0d exp 8", t_fill); end
    n_tests++; if (t_drop !== 16'd2) begin n_fail++; $display("FAIL ovf_drop got %0d exp 2", t_drop); end
    n_tests++; if (s_drop !== 4'd2) begin n_fail++; $display("FAIL ovf_sdrop got %0d exp 2", s_drop); end
    n_tests++; if (t_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", t_ovf); end
    trace_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) drive_retire(32'h128);
      exp_pc = (i < 8) ? 32'h100 + 32'(4 * i) : 32'h128;
      n_tests++; if (t_pc !== exp_pc) begin n_fail++; $display("FAIL ovf_drain_pc[%0d] got %h exp %h", i, t_pc, exp_pc); end
      n_tests++; if (t_flags[2] !== (i == 8)) begin n_fail++; $display("FAIL ovf_gap[%0d] got %b exp %b", i, t_flags[2], (i == 8)); end
      n_tests++; if (t_head !== exp_head()) begin n_fail++; $display("FAIL ovf_head[%0d] got %h exp %h", i, t_head, exp_head()); end
      tick();
    end
    n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b exp 0", t_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc;
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_retire(32'h200 + 32'(4 * i));
      tick();
    end
    trace_ready = 1'b1;
    drive_retire(32'h220);
    tick();
    n_tests++; if (t_drop !== 16'd2) begin n_fail++; $display("FAIL fp_drop got %0d exp 2", t_drop); end
    n_tests++; if (t_fill !== 4'd8) begin n_fail++; $display("FAIL fp_fill got %0d exp 8", t_fill); end
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'h204 + 32'(4 * i);
      n_tests++; if (t_pc !== exp_pc) begin n_fail++; $display("FAIL fp_drain_pc[%0d] got %h exp %h", i, t_pc, exp_pc); end
      n_tests++; if (t_head !== exp_head()) begin n_fail++; $display("FAIL fp_head[%0d] got %h exp %h", i, t_head, exp_head()); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rec_t held;
    trace_ready = 1'b0;
    drive_retire(32'h300);
    tick();
    held = exp_head();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_retire(32'h304 + 32'(4 * c));
      tick();
      n_tests++; if (t_head !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got %h exp %h", c, t_head, held); end
    end
    n_tests++; if (t_fill !== 4'd4) begin n_fail++; $display("FAIL bp_fill got %0d exp 4", t_fill); end
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (t_head !== exp_head()) begin n_fail++; $display("FAIL bp_drain[%0d] got %h exp %h", i, t_head, exp_head()); end
      tick();
    end
  endtask

  task automatic test_clear_enable();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_retire(32'h400 + 32'(4 * i));
      tick();
    end
    trace_ready = 1'b1;
    repeat (3) tick();
    trace_ready = 1'b0;
    clear = 1'b1;
    drive_retire(32'hDEAD_0000);
    tick();
    n_tests++; if (t_fill !== 4'd0) begin n_fail++; $display("FAIL clr_fill got %0d exp 0", t_fill); end
    n_tests++; if (t_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b exp 0", t_ovf); end
    n_tests++; if (t_drop !== 16'd0) begin n_fail++; $display("FAIL clr_drop got %0d exp 0", t_drop); end
    trace_ready = 1'b1;
    repeat (2) begin
      tick();
      n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL clr_discard got %b exp 0", t_valid); end
    end
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_retire(32'h480 + 32'(4 * i));
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_retire(32'h4C0 + 32'(4 * i));
      tick();
    end
    n_tests++; if (t_fill !== 4'd8) begin n_fail++; $display("FAIL en_fill got %0d exp 8", t_fill); end
    n_tests++; if (t_drop !== 16'd1) begin n_fail++; $display("FAIL en_drop got %0d exp 1", t_drop); end
    n_tests++; if (t_ovf !== 1'b1) begin n_fail++; $display("FAIL en_ovf got %b exp 1", t_ovf); end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (t_head !== exp_head()) begin n_fail++; $display("FAIL en_drain[%0d] got %h exp %h", i, t_head, exp_head()); end
      tick();
    end
    enable = 1'b1;
    drive_retire(32'h4F0);
    tick();
    n_tests++; if (t_pc !== 32'h4F0) begin n_fail++; $display("FAIL en_resume_pc got %h exp 4f0", t_pc); end
    n_tests++; if (t_flags[2] !== 1'b1) begin n_fail++; $display("FAIL en_gap_kept got %b exp 1", t_flags[2]); end
    tick();
  endtask

  task automatic test_saturation();
    clear = 1'b1;
    tick();
    trace_ready = 1'b0;
    for (int i = 0; i < 28; i++) begin
      drive_retire(32'h500 + 32'(4 * i));
      tick();
    end
    n_tests++; if (s_drop !== 4'hF) begin n_fail++; $display("FAIL sat_sdrop got %h exp f", s_drop); end
    n_tests++; if (t_drop !== 16'd20) begin n_fail++; $display("FAIL sat_drop got %0d exp 20", t_drop); end
    n_tests++; if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL sat_sovf got %b exp 1", s_ovf); end
  endtask

  task automatic test_async_reset();
    trace_ready = 1'b1;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if ({t_valid, t_head, t_fill, t_ovf, t_drop} !== '0) begin n_fail++; $display("FAIL arst_out got %h exp 0", {t_valid, t_head, t_fill, t_ovf, t_drop}); end
    n_tests++; if ({s_valid, s_pc, s_instr, s_flags, s_rd, s_wdata, s_fill, s_ovf, s_drop} !== '0) begin n_fail++; $display("FAIL arst_sout got nonzero exp 0"); end
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    n_tests++; if (t_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after got %b exp 0", t_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 6) drive_retire($urandom());
      trace_ready = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 9) != 0);
      clear       = ($urandom_range(0, 49) == 0);
      tick();
      n_tests++; if (t_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, t_valid, (exp_q.size() != 0)); end
      n_tests++; if (t_head !== exp_head()) begin n_fail++; $display("FAIL rnd_head[%0d] got %h exp %h", c, t_head, exp_head()); end
      n_tests++; if (32'(t_fill) !== exp_q.size()) begin n_fail++; $display("FAIL rnd_fill[%0d] got %0d exp %0d", c, t_fill, exp_q.size()); end
      n_tests++; if (t_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d] got %b exp %b", c, t_ovf, m_ovf); end
      n_tests++; if (t_drop !== 16'(exp_drop(65535))) begin n_fail++; $display("FAIL rnd_drop[%0d] got %0d exp %0d", c, t_drop, exp_drop(65535)); end
      n_tests++; if (s_drop !== 4'(exp_drop(15))) begin n_fail++; $display("FAIL rnd_sdrop[%0d] got %0d exp %0d", c, s_drop, exp_drop(15)); end
    end
    enable = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_full_pop();
    test_backpressure();
    test_clear_enable();
    test_saturation();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
